// File: rtl/dmem_vram.sv
// dmem_vram: lane-masked vector data memory with registered reads, bounds checks and a valid/ready dump sequencer
module dmem_vram #(
    parameter int S     = 32,
    parameter int LANES = 6,
    parameter int SIZE  = 30000,
    parameter int AW    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               isVector,
    input  logic               we,
    input  logic               re,
    input  logic [LANES-1:0]   lane_mask,
    input  logic [AW-1:0]      address,
    input  logic [LANES*S-1:0] wd,
    output logic [LANES*S-1:0] rd,
    output logic               rd_valid,
    output logic               oob_err,
    input  logic               switchStart,
    output logic [S-1:0]       dump_data,
    output logic [AW-1:0]      dump_addr,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic               dump_busy,
    output logic               dump_done
);
    localparam int MW = (SIZE > 1) ? $clog2(SIZE) : 1;
    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;
    state_t             state_q, state_d;
    logic [S-1:0]       mem_q [SIZE];
    logic [LANES*S-1:0] rd_q, rd_d;
    logic               rd_valid_q, rd_valid_d, oob_err_q, oob_err_d;
    logic [S-1:0]       dump_data_q, dump_data_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [1:0]         sync_q;
    logic               prev_q;
    logic [AW:0]        la [LANES];
    logic [LANES-1:0]   act, ok;
    logic               acc, trig;
    // lane addresses carry one extra bit so a base near the top of the range cannot wrap into memory
    always_comb begin
        acc = !dump_busy;
        rd_d = rd_q;
        for (int i = 0; i < LANES; i++) begin
            la[i] = {1'b0, address} + (AW+1)'(i);
            act[i] = isVector || i == 0;
            ok[i] = la[i] < (AW+1)'(SIZE);
            if (acc && re)
                rd_d[i*S +: S] = (act[i] && ok[i]) ? mem_q[la[i][MW-1:0]] : '0;
        end
        rd_valid_d = acc && re;
        oob_err_d = acc && (re || we) && |(act & ~ok);
    end
    always_ff @(posedge clk) begin
        if (!rst && acc && we)
            for (int i = 0; i < LANES; i++)
                if (act[i] && ok[i] && (!isVector || lane_mask[i]))
                    mem_q[la[i][MW-1:0]] <= wd[i*S +: S];
    end
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        dump_data_d = dump_data_q;
        trig = sync_q[1] && !prev_q;
        case (state_q)
            IDLE: if (trig) begin
                ptr_d = '0;
                state_d = FETCH;
            end
            FETCH: begin
                dump_data_d = mem_q[ptr_q[MW-1:0]];
                state_d = PRESENT;
            end
            PRESENT: if (dump_ready) begin
                if (ptr_q == AW'(SIZE - 1)) state_d = DONE;
                else begin
                    ptr_d = ptr_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            dump_data_q <= '0;
            rd_q <= '0;
            rd_valid_q <= 1'b0;
            oob_err_q <= 1'b0;
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            dump_data_q <= dump_data_d;
            rd_q <= rd_d;
            rd_valid_q <= rd_valid_d;
            oob_err_q <= oob_err_d;
            sync_q <= {sync_q[0], switchStart};
            prev_q <= sync_q[1];
        end
    end
    assign rd = rd_q;
    assign rd_valid = rd_valid_q;
    assign oob_err = oob_err_q;
    assign dump_data = dump_data_q;
    assign dump_addr = ptr_q;
    assign dump_valid = state_q == PRESENT;
    assign dump_busy = state_q == FETCH || state_q == PRESENT;
    assign dump_done = state_q == DONE;
endmodule
